roi_cfg_ctrl: RTL

ROI_CFG_CTRL -- requirements
Module: roi_cfg_ctrl

---
 rtl/roi_pkg.sv | 27 ++
 rtl/ascii_dec3.sv | 39 +++
 rtl/roi_cfg_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/roi_pkg.sv
// roi_pkg: shared FSM encoding, ASCII constants, error codes and field indexing for the ROI command parser.
package roi_pkg;

    typedef enum logic [1:0] {IDLE, RECV, TERM, CHECK} state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DIGIT   = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    localparam logic [7:0] ASC_DOLLAR = 8'h24;
    localparam logic [7:0] ASC_0      = 8'h30;
    localparam logic [7:0] ASC_9      = 8'h39;
    localparam logic [7:0] ASC_CR     = 8'h0D;

    function automatic logic is_digit(input logic [7:0] b);
        return b >= ASC_0 && b <= ASC_9;
    endfunction

    // digit counter 0..11 maps to field x,y,w,h three digits at a time
    function automatic logic [1:0] field_of(input logic [3:0] c);
        return (c < 4'd3) ? 2'd0 : (c < 4'd6) ? 2'd1 : (c < 4'd9) ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/ascii_dec3.sv
// ascii_dec3: accumulates three ASCII decimal digits (MSD first) into a binary value.
module ascii_dec3
    import roi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic       digit_ok,
    output logic       done,
    output logic [9:0] value
);

    logic [9:0]  acc;
    logic [1:0]  pos;
    logic [13:0] nxt;
    logic        unused_hi;

    assign digit_ok  = is_digit(data);
    assign nxt       = 14'(acc) * 14'd10 + 14'(data - ASC_0);
    assign value     = nxt[9:0];
    assign unused_hi = ^nxt[13:10];
    assign done      = en && digit_ok && pos == 2'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            pos <= '0;
        end else if (clr || done) begin
            acc <= '0;
            pos <= '0;
        end else if (en && digit_ok) begin
            acc <= nxt[9:0];
            pos <= pos + 2'd1;
        end
    end

endmodule

// File: rtl/roi_cfg_ctrl.sv
// roi_cfg_ctrl: parses "$xxxyyywwwhhh<CR>" UART frames, validates the region and
// commits it to x/y/w/h on the next video frame boundary.
module roi_cfg_ctrl
    import roi_pkg::*;
#(
    parameter int TIMEOUT_CYC = 208320,
    parameter int H_MAX       = 640,
    parameter int V_MAX       = 480
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    input  logic       frame_start,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [9:0] w,
    output logic [9:0] h,
    output logic       cfg_update,
    output logic       pending,
    output logic       busy,
    output logic       err_pulse,
    output logic [1:0] err_code
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0][9:0] RST_ROI = {10'(V_MAX), 10'(H_MAX), 10'd0, 10'd0};

    state_t          state, nstate;
    err_t            err_val;
    logic [3:0]      cnt;
    logic [TW-1:0]   tcnt;
    logic [3:0][9:0] sh, pnd, cur;
    logic [9:0]      dec_val;
    logic            dec_ok, dec_done, dec_en;
    logic            is_dollar, in_frame, timeout, restart, chk_ok, chk_valid, err_set;

    assign dec_en    = state == RECV && pi_flag;
    assign is_dollar = pi_flag && pi_data == ASC_DOLLAR;
    assign in_frame  = state == RECV || state == TERM;
    assign timeout   = in_frame && !pi_flag && tcnt == TW'(TIMEOUT_CYC - 1);
    assign chk_ok    = |sh[2] && |sh[3] &&
                       {1'b0, sh[0]} + {1'b0, sh[2]} <= 11'(H_MAX) &&
                       {1'b0, sh[1]} + {1'b0, sh[3]} <= 11'(V_MAX);
    assign chk_valid = state == CHECK && chk_ok;
    assign busy      = state != IDLE;
    assign {h, w, y, x} = cur;

    ascii_dec3 u_dec (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .clr      (restart),
        .en       (dec_en),
        .data     (pi_data),
        .digit_ok (dec_ok),
        .done     (dec_done),
        .value    (dec_val)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= nstate;
    end

    always_comb begin
        nstate  = state;
        restart = 1'b0;
        err_set = 1'b0;
        err_val = ERR_NONE;
        if (timeout) begin
            nstate  = IDLE;
            err_set = 1'b1;
            err_val = ERR_TIMEOUT;
        end else begin
            case (state)
                IDLE: begin
                    restart = is_dollar;
                    nstate  = is_dollar ? RECV : IDLE;
                end
                RECV: begin
                    if (is_dollar) restart = 1'b1;
                    else if (pi_flag && dec_ok) nstate = (cnt == 4'd11) ? TERM : RECV;
                    else if (pi_flag) begin
                        nstate  = IDLE;
                        err_set = 1'b1;
                        err_val = ERR_DIGIT;
                    end
                end
                TERM: begin
                    if (is_dollar) begin
                        restart = 1'b1;
                        nstate  = RECV;
                    end else if (pi_flag && pi_data == ASC_CR) nstate = CHECK;
                    else if (pi_flag) begin
                        nstate  = IDLE;
                        err_set = 1'b1;
                        err_val = ERR_DIGIT;
                    end
                end
                CHECK: begin
                    nstate  = IDLE;
                    err_set = !chk_ok;
                    err_val = ERR_RANGE;
                end
                default: nstate = IDLE;
            endcase
        end
    end

    // a commit uses the old pending value even when CHECK overwrites it on the same edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt        <= '0;
            tcnt       <= '0;
            sh         <= '0;
            pnd        <= RST_ROI;
            cur        <= RST_ROI;
            pending    <= 1'b0;
            cfg_update <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            cnt        <= restart ? 4'd0 : (dec_en && dec_ok) ? ((cnt == 4'd11) ? 4'd0 : cnt + 4'd1) : cnt;
            tcnt       <= (in_frame && !pi_flag) ? tcnt + 1'b1 : '0;
            if (dec_done) sh[field_of(cnt)] <= dec_val;
            if (chk_valid) pnd <= sh;
            if (frame_start && pending) cur <= pnd;
            cfg_update <= frame_start && pending;
            pending    <= chk_valid || (pending && !frame_start);
            err_pulse  <= err_set;
            if (err_set) err_code <= err_val;
        end
    end

endmodule
